// File: rtl/alu_pkg.sv
// Shared types for the ALU sharing controller: ALU opcodes, controller states and
// NZCV bit positions.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } ctrl_state_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_nzcv.sv
// Combinational ALU with ARM-style NZCV flags. SUB carry means "no borrow";
// logical ops clear C and V.
module alu_nzcv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_ctrl_t        ctrl,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       nzcv
);

  logic [WIDTH:0] sum;
  logic           c;
  logic           v;

  always_comb begin
    sum = '0;
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    unique case (ctrl)
      ALU_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: res = a & b;
      ALU_ORR: res = a | b;
      default: res = '0;
    endcase
  end

  always_comb begin
    nzcv         = '0;
    nzcv[FLAG_N] = res[WIDTH-1];
    nzcv[FLAG_Z] = (res == '0);
    nzcv[FLAG_C] = c;
    nzcv[FLAG_V] = v;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  logic        found;
  logic [PW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PW'((32'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares a single alu_nzcv between NREQ requesters: round-robin grant, registered
// operands, held response and a saved NZCV register per requester.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_ctrl,
  input  logic [NREQ-1:0]       req_setflags,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_res,
  output logic [3:0]            rsp_nzcv,
  output logic [NREQ*4-1:0]     flags_q
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  ctrl_state_t      state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, owner_q, owner_d, grant_idx;
  logic [NREQ-1:0]  grant;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, rsp_res_d, alu_res;
  alu_ctrl_t        ctrl_q, ctrl_d;
  logic             setflags_q, setflags_d;
  logic [3:0]       rsp_nzcv_d, alu_flags;
  logic [NREQ*4-1:0] flags_d;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  alu_nzcv #(.WIDTH(WIDTH)) u_alu (
    .a    (a_q),
    .b    (b_q),
    .ctrl (ctrl_q),
    .res  (alu_res),
    .nzcv (alu_flags)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    setflags_d = setflags_q;
    rsp_res_d  = rsp_res;
    rsp_nzcv_d = rsp_nzcv;
    flags_d    = flags_q;
    req_ready  = '0;
    rsp_valid  = '0;
    unique case (state_q)
      IDLE: begin
        // No grant is offered while reset is asserted, so nothing is accepted.
        if (reset_n && (grant != '0)) begin
          req_ready = grant;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
              a_d        = req_a[i*WIDTH +: WIDTH];
              b_d        = req_b[i*WIDTH +: WIDTH];
              ctrl_d     = alu_ctrl_t'(req_ctrl[i*2 +: 2]);
              setflags_d = req_setflags[i];
            end
          end
          owner_d = grant_idx;
          ptr_d   = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_res_d  = alu_res;
        rsp_nzcv_d = alu_flags;
        if (setflags_q) begin
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner_q == PW'(i)) flags_d[i*4 +: 4] = alu_flags;
          end
        end
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= ALU_ADD;
      setflags_q <= 1'b0;
      rsp_res    <= '0;
      rsp_nzcv   <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctrl_q     <= ctrl_d;
      setflags_q <= setflags_d;
      rsp_res    <= rsp_res_d;
      rsp_nzcv   <= rsp_nzcv_d;
      flags_q    <= flags_d;
    end
  end

endmodule
